// File: rtl/mult8x8_ctrl_pkg.sv
// Shared definitions for the 8x8 sequential multiplier: state codes, mux and
// shifter select constants, and the Moore output decode used by the controller.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LSB  = 3'd2,
    ST_MID  = 3'd3,
    ST_MSB  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // input_sel bit0 picks the A nibble, bit1 picks the B nibble (1 = high nibble)
  localparam logic [1:0] SEL_LL = 2'b00;
  localparam logic [1:0] SEL_HL = 2'b01;
  localparam logic [1:0] SEL_LH = 2'b10;
  localparam logic [1:0] SEL_HH = 2'b11;

  localparam logic [1:0] SHIFT_0 = 2'd0;
  localparam logic [1:0] SHIFT_4 = 2'd1;
  localparam logic [1:0] SHIFT_8 = 2'd2;

  typedef struct packed {
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       busy;
    logic       done;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outputs(state_e st, logic mid_cnt);
    ctrl_out_t o;
    o.input_sel = SEL_LL;
    o.shift_sel = SHIFT_0;
    o.clk_ena   = 1'b0;
    o.sclr_n    = 1'b1;
    o.busy      = 1'b0;
    o.done      = 1'b0;
    case (st)
      ST_CLR: begin
        o.clk_ena = 1'b1;
        o.sclr_n  = 1'b0;
        o.busy    = 1'b1;
      end
      ST_LSB: begin
        o.clk_ena = 1'b1;
        o.busy    = 1'b1;
      end
      ST_MID: begin
        o.clk_ena   = 1'b1;
        o.busy      = 1'b1;
        o.input_sel = mid_cnt ? SEL_LH : SEL_HL;
        o.shift_sel = SHIFT_4;
      end
      ST_MSB: begin
        o.clk_ena   = 1'b1;
        o.busy      = 1'b1;
        o.input_sel = SEL_HH;
        o.shift_sel = SHIFT_8;
      end
      ST_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mult8x8_ctrl_if.sv
// Control bundle between the multiplier controller (master) and the datapath (slave).
interface mult8x8_ctrl_if;

  logic       start;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic       clk_ena;
  logic       sclr_n;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

  modport master (
    input  start,
    output input_sel,
    output shift_sel,
    output clk_ena,
    output sclr_n,
    output busy,
    output done,
    output state_out
  );

  modport slave (
    output start,
    input  input_sel,
    input  shift_sel,
    input  clk_ena,
    input  sclr_n,
    input  busy,
    input  done,
    input  state_out
  );

endinterface

// File: rtl/mult8x8_ctrl.sv
// Control FSM for the 8x8 sequential multiplier: one clear cycle then four
// shifted 4x4 partial-product accumulations, with glitch-free registered outputs.
module mult8x8_ctrl
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             aclr_n,
  mult8x8_ctrl_if.master   bus
);

  localparam ctrl_out_t OUT_RESET = '{
    input_sel: SEL_LL,
    shift_sel: SHIFT_0,
    clk_ena:   1'b0,
    sclr_n:    1'b1,
    busy:      1'b0,
    done:      1'b0
  };

  state_e    state_q, state_d;
  logic      mid_cnt_q, mid_cnt_d;
  ctrl_out_t out_q, out_d;

  // Outputs are decoded from the next state and registered alongside it, so
  // they always match the registered state without any path from start.
  always_comb begin
    state_d   = state_q;
    mid_cnt_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = bus.start ? ST_CLR : ST_IDLE;
      ST_CLR:  state_d = ST_LSB;
      ST_LSB:  state_d = ST_MID;
      ST_MID: begin
        if (mid_cnt_q) begin
          state_d = ST_MSB;
        end else begin
          state_d   = ST_MID;
          mid_cnt_d = 1'b1;
        end
      end
      ST_MSB:  state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_CLR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    out_d = decode_outputs(state_d, mid_cnt_d);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      mid_cnt_q <= 1'b0;
      out_q     <= OUT_RESET;
    end else begin
      state_q   <= state_d;
      mid_cnt_q <= mid_cnt_d;
      out_q     <= out_d;
    end
  end

  assign bus.input_sel = out_q.input_sel;
  assign bus.shift_sel = out_q.shift_sel;
  assign bus.clk_ena   = out_q.clk_ena;
  assign bus.sclr_n    = out_q.sclr_n;
  assign bus.busy      = out_q.busy;
  assign bus.done      = out_q.done;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Bench for mult8x8_ctrl: wraps the controller with a behavioural 8x8 datapath
// and checks per-cycle control sequences and final products against A*B.
module tb_mult8x8_ctrl;

  logic        clk;
  logic        aclr_n;
  logic [7:0]  a_val;
  logic [7:0]  b_val;
  logic [15:0] acc;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [7:0]  pp;
  int          shift_amt;
  int          checks;
  int          errors;

  mult8x8_ctrl_if bus();

  mult8x8_ctrl dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: nibble mux, 4x4 multiplier, shifter, adder and accumulator
  always_comb begin
    a_nib = bus.input_sel[0] ? a_val[7:4] : a_val[3:0];
    b_nib = bus.input_sel[1] ? b_val[7:4] : b_val[3:0];
    pp    = 8'(a_nib * b_nib);
    case (bus.shift_sel)
      2'd1:    shift_amt = 4;
      2'd2:    shift_amt = 8;
      default: shift_amt = 0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.clk_ena) begin
      if (!bus.sclr_n) acc <= 16'h0000;
      else             acc <= acc + (16'(pp) << shift_amt);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " state_out"}, 32'(bus.state_out), 32'd0);
    check_output({tag, " busy"},      32'(bus.busy),      32'd0);
    check_output({tag, " done"},      32'(bus.done),      32'd0);
    check_output({tag, " clk_ena"},   32'(bus.clk_ena),   32'd0);
    check_output({tag, " sclr_n"},    32'(bus.sclr_n),    32'd1);
    check_output({tag, " input_sel"}, 32'(bus.input_sel), 32'd0);
    check_output({tag, " shift_sel"}, 32'(bus.shift_sel), 32'd0);
  endtask

  // Runs one multiply starting from IDLE or DONE, #1 after an edge. start_mask
  // bit k is driven during busy cycle k (CLR, LSB, MID, MID, MSB) and must be ignored.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [4:0] start_mask, input logic hold);
    logic [2:0] exp_state [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
    logic [1:0] exp_isel  [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] exp_ssel  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [15:0] product;
    product   = 16'(a) * 16'(b);
    a_val     = a;
    b_val     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus.start = start_mask[k];
      check_output($sformatf("c%0d state_out", k), 32'(bus.state_out), 32'(exp_state[k]));
      check_output($sformatf("c%0d busy", k),      32'(bus.busy),      32'd1);
      check_output($sformatf("c%0d done", k),      32'(bus.done),      32'd0);
      check_output($sformatf("c%0d clk_ena", k),   32'(bus.clk_ena),   32'd1);
      check_output($sformatf("c%0d sclr_n", k),    32'(bus.sclr_n),    (k == 0) ? 32'd0 : 32'd1);
      check_output($sformatf("c%0d input_sel", k), 32'(bus.input_sel), 32'(exp_isel[k]));
      check_output($sformatf("c%0d shift_sel", k), 32'(bus.shift_sel), 32'(exp_ssel[k]));
      @(posedge clk); #1;
    end
    bus.start = hold;
    check_output("done state_out", 32'(bus.state_out), 32'd5);
    check_output("done done",      32'(bus.done),      32'd1);
    check_output("done busy",      32'(bus.busy),      32'd0);
    check_output("done clk_ena",   32'(bus.clk_ena),   32'd0);
    check_output($sformatf("product %02h*%02h", a, b), 32'(acc), 32'(product));
    if (!hold) begin
      @(posedge clk); #1;
      check_idle_outputs("after done");
      check_output("acc held", 32'(acc), 32'(product));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [4:0] rmask;
    logic       rhold;
    checks    = 0;
    errors    = 0;
    aclr_n    = 1'b0;
    bus.start = 1'b0;
    a_val     = 8'h00;
    b_val     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk) aclr_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle no start");

    apply_stimulus(8'hFF, 8'hFF, 5'b00000, 1'b0);
    apply_stimulus(8'h12, 8'h34, 5'b00000, 1'b0);
    apply_stimulus(8'h0F, 8'h10, 5'b00000, 1'b1);
    apply_stimulus(8'h03, 8'h05, 5'b00000, 1'b0);
    apply_stimulus(8'h5A, 8'hC3, 5'b10010, 1'b0);
    @(posedge clk); #1;
    check_output("single done pulse", 32'(bus.done), 32'd0);

    // Abort in MID with an asynchronous reset, then restart cleanly
    a_val     = 8'hEE;
    b_val     = 8'hDD;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_output("pre-abort state_out", 32'(bus.state_out), 32'd3);
    #3 aclr_n = 1'b0;
    #1;
    check_idle_outputs("async reset mid-op");
    @(negedge clk) aclr_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after abort");
    apply_stimulus(8'h02, 8'h03, 5'b00000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rmask = 5'($urandom);
      rhold = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      apply_stimulus(ra, rb, rmask, rhold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
